// File: rtl/spi_ram_pkg.sv
// Shared opcodes, FSM encoding and helpers for the SPI-to-RAM burst bridge.
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPC     = 3'd1,
    ST_WR_ADDR = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_RD_DATA = 3'd5,
    ST_HOLD    = 3'd6
  } state_t;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM with registered read; contents are never reset.
module spi_ram_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

  // One access per cycle: a write, or a registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= din;
    end else begin
      dout <= r_mem[addr];
    end
  end

endmodule

// File: rtl/spi_ram_burst.sv
// SPI slave bridged to an on-chip RAM: 2-bit opcode, then address load or
// burst data with auto-incrementing, wrapping read/write pointers.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int RX_W  = max_int(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(RX_W) + 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] PTR_STEP  = (AUTO_INC != 0) ? ADDR_W'(1) : ADDR_W'(0);

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_op_hi;
  logic [RX_W-2:0]     r_rx;
  logic [DATA_W-2:0]   r_tx;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic                r_miso;

  logic [RX_W-1:0]     w_rx_next;
  logic [1:0]          w_opcode;
  logic                w_addr_last;
  logic                w_data_last;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_din;
  logic [DATA_W-1:0]   w_mem_dout;

  assign w_rx_next   = {r_rx, MOSI};
  assign w_opcode    = {r_op_hi, MOSI};
  assign w_addr_last = (r_cnt == ADDR_LAST);
  assign w_data_last = (r_cnt == DATA_LAST);
  assign MISO        = r_miso;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: any edge with SS_n high ends the frame.
  always_comb begin
    w_next_state = r_state;
    if (SS_n) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_next_state = ST_OPC;
        ST_OPC: begin
          case (w_opcode)
            OP_WR_ADDR: w_next_state = ST_WR_ADDR;
            OP_WR_DATA: w_next_state = ST_WR_DATA;
            OP_RD_ADDR: w_next_state = ST_RD_ADDR;
            OP_RD_DATA: w_next_state = ST_RD_DATA;
            default:    w_next_state = ST_IDLE;
          endcase
        end
        ST_WR_ADDR, ST_RD_ADDR: begin
          if (w_addr_last) begin
            w_next_state = ST_HOLD;
          end else begin
            w_next_state = r_state;
          end
        end
        ST_WR_DATA, ST_RD_DATA, ST_HOLD: w_next_state = r_state;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: RAM strobe and address mux. The read pointer is the default
  // address so the first read word is fetched on the opcode edge; on the LSB
  // edge of a read word the next word is prefetched.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = r_rd_ptr;
    w_mem_din  = w_rx_next[DATA_W-1:0];
    if (r_state == ST_WR_DATA) begin
      w_mem_addr = r_wr_ptr;
      if (!SS_n && w_data_last) begin
        w_mem_we = 1'b1;
      end else begin
        w_mem_we = 1'b0;
      end
    end else if ((r_state == ST_RD_DATA) && w_data_last) begin
      w_mem_addr = r_rd_ptr + PTR_STEP;
    end else begin
      w_mem_addr = r_rd_ptr;
    end
  end

  // Datapath: bit counter, shifters, pointers and the registered MISO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= CNT_ZERO;
      r_op_hi  <= 1'b0;
      r_rx     <= '0;
      r_tx     <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_miso   <= 1'b0;
    end else if (SS_n) begin
      r_cnt  <= CNT_ZERO;
      r_rx   <= '0;
      r_tx   <= '0;
      r_miso <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_op_hi <= MOSI;
          r_cnt   <= CNT_ZERO;
          r_miso  <= 1'b0;
        end
        ST_OPC: begin
          r_cnt  <= CNT_ZERO;
          r_miso <= 1'b0;
        end
        ST_WR_ADDR: begin
          r_rx  <= w_rx_next[RX_W-2:0];
          r_cnt <= r_cnt + CNT_ONE;
          if (w_addr_last) begin
            r_wr_ptr <= w_rx_next[ADDR_W-1:0];
          end
        end
        ST_RD_ADDR: begin
          r_rx  <= w_rx_next[RX_W-2:0];
          r_cnt <= r_cnt + CNT_ONE;
          if (w_addr_last) begin
            r_rd_ptr <= w_rx_next[ADDR_W-1:0];
          end
        end
        ST_WR_DATA: begin
          r_rx <= w_rx_next[RX_W-2:0];
          if (w_data_last) begin
            r_cnt    <= CNT_ZERO;
            r_wr_ptr <= r_wr_ptr + PTR_STEP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_RD_DATA: begin
          if (r_cnt == CNT_ZERO) begin
            r_miso <= w_mem_dout[DATA_W-1];
            r_tx   <= w_mem_dout[DATA_W-2:0];
          end else begin
            r_miso <= r_tx[DATA_W-2];
            r_tx   <= r_tx << 1;
          end
          if (w_data_last) begin
            r_cnt    <= CNT_ZERO;
            r_rd_ptr <= r_rd_ptr + PTR_STEP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_HOLD: r_miso <= 1'b0;
        default: begin
          r_cnt  <= CNT_ZERO;
          r_miso <= 1'b0;
        end
      endcase
    end
  end

  spi_ram_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk (clk),
    .we  (w_mem_we),
    .addr(w_mem_addr),
    .din (w_mem_din),
    .dout(w_mem_dout)
  );

endmodule

// File: tb/tb_spi_ram_burst.sv
// Self-checking bench for spi_ram_burst: vector table plus hand-written frames.
module tb_spi_ram_burst;
  import spi_ram_pkg::*;

  logic clk;
  logic rst_n;
  logic SS_n;
  logic MOSI;
  logic MISO;

  int total;
  int bad;
  logic exp_q[$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [5];

  spi_ram_burst #(.ADDR_W(8), .DATA_W(8), .AUTO_INC(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .SS_n (SS_n),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic ss, input logic mosi);
    @(negedge clk);
    SS_n = ss;
    MOSI = mosi;
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    tick(1'b1, 1'b0);
    chk("miso_after_frame", 32'(MISO), 32'd0);
  endtask

  task automatic send_opc(input logic [1:0] op);
    tick(1'b0, op[1]);
    chk("miso_e1", 32'(MISO), 32'd0);
    tick(1'b0, op[0]);
    chk("miso_e2", 32'(MISO), 32'd0);
  endtask

  task automatic addr_frame(input logic [1:0] op, input logic [7:0] a);
    send_opc(op);
    for (int i = 7; i >= 0; i--) tick(1'b0, a[i]);
    tick(1'b0, 1'b1);
    gap();
  endtask

  task automatic wr_words(input logic [31:0] w, input int n);
    logic [7:0] wd;
    send_opc(OP_WR_DATA);
    for (int k = 0; k < n; k++) begin
      wd = w[8*(n-1-k) +: 8];
      for (int b = 7; b >= 0; b--) tick(1'b0, wd[b]);
    end
    gap();
  endtask

  task automatic rd_expect(input logic [31:0] w, input int n);
    logic [7:0] wd;
    logic e;
    for (int k = 0; k < n; k++) begin
      wd = w[8*(n-1-k) +: 8];
      for (int b = 7; b >= 0; b--) exp_q.push_back(wd[b]);
    end
    send_opc(OP_RD_DATA);
    for (int i = 0; i < 8*n; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)));
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("miso_bit", 32'(MISO), 32'(e));
      end
    end
    gap();
  endtask

  initial begin
    vecs[0] = '{addr: 8'h05, wdata: 8'h5C, exp_rd: 8'h5C};
    vecs[1] = '{addr: 8'h80, wdata: 8'hFF, exp_rd: 8'hFF};
    vecs[2] = '{addr: 8'h7F, wdata: 8'h00, exp_rd: 8'h00};
    vecs[3] = '{addr: 8'hC4, wdata: 8'h81, exp_rd: 8'h81};
    vecs[4] = '{addr: 8'h06, wdata: 8'h6E, exp_rd: 8'h6E};

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'b0);
    chk("reset_miso", 32'(MISO), 32'd0);
    chk("reset_state", 32'(dut.r_state), 32'(ST_IDLE));

    // No address frame yet: both pointers start at 0.
    wr_words(32'h3C, 1);
    rd_expect(32'h3C, 1);

    for (int i = 0; i < 5; i++) begin
      addr_frame(OP_WR_ADDR, vecs[i].addr);
      wr_words(32'(vecs[i].wdata), 1);
      addr_frame(OP_RD_ADDR, vecs[i].addr);
      rd_expect(32'(vecs[i].exp_rd), 1);
    end
    for (int i = 0; i < 5; i++) begin
      addr_frame(OP_RD_ADDR, vecs[i].addr);
      rd_expect(32'(vecs[i].exp_rd), 1);
    end

    // Single word: A5 streams 1,0,1,0,0,1,0,1.
    addr_frame(OP_WR_ADDR, 8'h10);
    wr_words(32'hA5, 1);
    addr_frame(OP_RD_ADDR, 8'h10);
    rd_expect(32'hA5, 1);

    // Three-word burst, then contiguous 24-bit read.
    addr_frame(OP_WR_ADDR, 8'h20);
    wr_words(32'h112233, 3);
    addr_frame(OP_RD_ADDR, 8'h20);
    rd_expect(32'h112233, 3);
    addr_frame(OP_RD_ADDR, 8'h22);
    rd_expect(32'h33, 1);

    // Pointer wrap 0xFF -> 0x00 on both write and read.
    addr_frame(OP_WR_ADDR, 8'hFF);
    wr_words(32'hAABB, 2);
    addr_frame(OP_RD_ADDR, 8'hFF);
    rd_expect(32'hAABB, 2);
    addr_frame(OP_RD_ADDR, 8'h00);
    rd_expect(32'hBB, 1);

    // Abort after 5 data bits: no write, no pointer change.
    addr_frame(OP_WR_ADDR, 8'h30);
    wr_words(32'h77, 1);
    addr_frame(OP_WR_ADDR, 8'h30);
    send_opc(OP_WR_DATA);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    gap();
    addr_frame(OP_RD_ADDR, 8'h30);
    rd_expect(32'h77, 1);
    wr_words(32'h5A, 1);
    addr_frame(OP_RD_ADDR, 8'h30);
    rd_expect(32'h5A, 1);

    // Reset in the middle of an RD_DATA burst.
    addr_frame(OP_WR_ADDR, 8'h40);
    wr_words(32'hC3C3, 2);
    addr_frame(OP_RD_ADDR, 8'h40);
    send_opc(OP_RD_DATA);
    tick(1'b0, 1'b0);
    chk("midrst_msb", 32'(MISO), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    SS_n  = 1'b1;
    #1;
    chk("midrst_miso", 32'(MISO), 32'd0);
    chk("midrst_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("midrst_rd_ptr", 32'(dut.r_rd_ptr), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'b0);
    chk("postrst_miso", 32'(MISO), 32'd0);
    rd_expect(32'hBB, 1);
    addr_frame(OP_RD_ADDR, 8'h40);
    rd_expect(32'hC3C3, 2);
    addr_frame(OP_RD_ADDR, 8'h10);
    rd_expect(32'hA5, 1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_ram_burst.md
# spi_ram_burst

Parametrised successor to the team's SPI-slave-plus-RAM wrapper: a single-clock SPI slave bridged to a synchronous on-chip RAM. Address and data widths are parameters. Data commands support burst transfers: write and read pointers auto-increment (with wrap) while `SS_n` stays low. Read data streams on `MISO` with no dummy phase. It sits at the chip's serial configuration/debug port.

## Interface
- `ADDR_W`, 8, address width; RAM depth = 2**ADDR_W
- `DATA_W`, 8, word width
- `AUTO_INC`, 1, 1 = pointers advance after each burst word; 0 = burst repeats the same address
- `clk`  in  1  sole clock; all sampling on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `SS_n`  in  1  slave select, active low; low = frame in progress
- `MOSI`  in  1  serial input, MSB first, sampled on rising `clk`
- `MISO`  out  1  serial output, MSB first, registered; 0 when not transmitting

## Operation
- Frame: 2-bit opcode, then payload. Opcodes: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- E1 = first rising edge with `SS_n`=0. E1 and E2 sample opcode bits [1] and [0]; payload starts at E3.
- WR_ADDR / RD_ADDR: ADDR_W payload bits shift into `wr_ptr` / `rd_ptr`, loaded at the edge sampling the LSB. Further bits in the same frame are ignored (HOLD).
- WR_DATA: every DATA_W bits form one word, written to mem[`wr_ptr`] at the edge sampling its LSB. `wr_ptr` advances at that same edge if AUTO_INC. The next bit starts the next word. There is no limit on burst length.
- RD_DATA: `MOSI` is ignored.
  - The read of mem[`rd_ptr`] is issued at E2. The shift register loads at E3.
  - The word streams MSB first. After the LSB the next word follows with no gap: it is prefetched and `rd_ptr` advances during the LSB cycle when AUTO_INC.
- Pointer arithmetic is modulo 2**ADDR_W: 2**ADDR_W-1 wraps to 0.
- States: IDLE, OPC, WR_ADDR, RD_ADDR, WR_DATA, RD_DATA, HOLD.
  - IDLE→OPC at E1. OPC→payload state at E2.
  - Address states→HOLD after the LSB.
  - Any state→IDLE on any edge sampling `SS_n`=1.
- Abort: `SS_n` high mid-word discards the partial word. There is no write, and no pointer change on that word. Completed burst words remain written.
- Memory contents are not reset and are held across reset.

## Timing
- Reset values: state IDLE, `MISO`=0, `wr_ptr`=0, `rd_ptr`=0, bit counter 0, shift registers 0.
- Asynchronous reset applies immediately, including mid-frame: the frame is dropped and no write occurs.
- RD_DATA timing: bit i of word n is valid on `MISO` from edge E3+n·DATA_W+(DATA_W-1-i) until the next edge.
- `MISO` returns to 0 on the first edge sampling `SS_n`=1.
- Write latency: data is readable by an RD_DATA frame started on any later edge.
- Minimum gap between frames is one edge with `SS_n`=1.
- A data frame before any address frame uses pointer 0.
- Read and write pointers are independent. The RAM sees at most one access per cycle, because a frame is either read or write.

## Structure
- Package `spi_ram_pkg`: opcode localparams (OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA) and the state enum/encoding.
- Sub-module `spi_ram_mem`, parameters ADDR_W and DATA_W:
  - single-port synchronous RAM with ports `clk`, `we`, `addr`, `din`, `dout`;
  - registered read.
- Top level: FSM, bit counter (width $clog2(max(ADDR_W,DATA_W))+1), rx/tx shifters, pointers, and the address mux into `spi_ram_mem`.

## Test plan
All scenarios use default parameters (ADDR_W=DATA_W=8, AUTO_INC=1).
- Reset: assert `rst_n`=0 with `SS_n`=1, then release. Expect `MISO`=0. An RD_DATA frame with no prior address frame reads mem[0x00].
- Single write/read:
  - WR_ADDR 0x10, then WR_DATA 0xA5. Expect mem[0x10]=0xA5.
  - Then RD_ADDR 0x10 and RD_DATA for 8 bits. Expect `MISO`=1,0,1,0,0,1,0,1 starting at E3.
- Burst:
  - WR_ADDR 0x20, then one WR_DATA frame carrying 0x11,0x22,0x33. Expect mem[0x20..0x22]=0x11,0x22,0x33.
  - Then RD_ADDR 0x20 and a 24-bit RD_DATA. Expect `MISO` shows 0x110x220x33 contiguous from E3.
- Wrap: WR_ADDR 0xFF, then burst 0xAA,0xBB. Expect mem[0xFF]=0xAA and mem[0x00]=0xBB.
- Abort: WR_ADDR 0x30, then WR_DATA with `SS_n` raised after 5 data bits. Expect mem[0x30] unchanged, and the next full WR_DATA 0x5A lands at 0x30.
- Reset mid-frame: `rst_n`=0 during an RD_DATA burst. Expect `MISO`=0 immediately, state IDLE, `rd_ptr`=0, and memory preserved.
